// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the zero-register constant and the forward-select encoding
// used by the ID/EX stage and its operand forwarding muxes.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_MW   = 2'd1,
    FWD_EXM  = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Per-source operand select: r0 reads zero, then EX/MEM, then MEM/WB, then
// the register file. EX/MEM is newest so it must win over MEM/WB.
module operand_fwd
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int unsigned REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exm_regWr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mw_regWr,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [DATA_W-1:0] mw_result,
  output logic [DATA_W-1:0] operand
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (rs == REG_AW'(ZERO_REG))
      sel = FWD_ZERO;
    else if (exm_regWr && (exm_rd == rs))
      sel = FWD_EXM;
    else if (mw_regWr && (mw_rd == rs))
      sel = FWD_MW;
  end

  always_comb begin
    operand = rf_data;
    unique case (sel)
      FWD_ZERO: operand = '0;
      FWD_EXM:  operand = exm_result;
      FWD_MW:   operand = mw_result;
      FWD_RF:   operand = rf_data;
      default:  operand = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and branch flush. Flush beats stall; bubbles clear controls but hold data.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int unsigned REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regWr,
  input  logic              id_memRd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic              exm_regWr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mw_regWr,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [DATA_W-1:0] mw_result,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_regWr,
  output logic              ex_memRd,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic [DATA_W-1:0] ex_imm
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .rs         (id_rs1),
    .rf_data    (busA),
    .exm_regWr  (exm_regWr),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .mw_regWr   (mw_regWr),
    .mw_rd      (mw_rd),
    .mw_result  (mw_result),
    .operand    (fwd_a)
  );

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .rs         (id_rs2),
    .rf_data    (busB),
    .exm_regWr  (exm_regWr),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .mw_regWr   (mw_regWr),
    .mw_rd      (mw_rd),
    .mw_result  (mw_result),
    .operand    (fwd_b)
  );

  // Loaded value is not available until MEM/WB, so a dependent op waits one cycle.
  always_comb begin
    stall = 1'b0;
    if (reset && id_valid && ex_valid && ex_memRd && !ex_flush &&
        (ex_rd != REG_AW'(ZERO_REG)) &&
        ((ex_rd == id_rs1) || (ex_rd == id_rs2)))
      stall = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_regWr <= 1'b0;
      ex_memRd <= 1'b0;
      ex_rd    <= '0;
      ex_opA   <= '0;
      ex_opB   <= '0;
      ex_imm   <= '0;
    end else if (ex_flush || stall) begin
      ex_valid <= 1'b0;
      ex_regWr <= 1'b0;
      ex_memRd <= 1'b0;
    end else begin
      ex_valid <= id_valid;
      ex_regWr <= id_regWr & id_valid;
      ex_memRd <= id_memRd & id_valid;
      ex_rd    <= id_rd;
      ex_opA   <= fwd_a;
      ex_opB   <= fwd_b;
      ex_imm   <= id_imm;
    end
  end

endmodule
